// File: rtl/mul_div_pkg.sv
// mul_div_pkg: op codes, FSM states and op-class helpers shared by the
// RV64M multiply/divide unit and its bench.
package mul_div_pkg;

    localparam int unsigned OP_SEL_W = 4;

    typedef enum logic [OP_SEL_W-1:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    function automatic logic is_mul_op(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    endfunction

    function automatic logic is_div_op(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_rem_op(input op_e op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_word_op(input op_e op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    // rs1 is interpreted as a signed value by these ops
    function automatic logic is_signed_op(input op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// div_iter: radix-2 restoring divider on unsigned magnitudes. One quotient
// bit per cycle; word ops run half the iterations on the low half.
module div_iter #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned CNT_SIZE = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_kill,
    input  logic            i_start,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_last,
    output logic [XLEN-1:0] o_quo,
    output logic [XLEN-1:0] o_rem
);

    localparam int unsigned HALF = XLEN / 2;

    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_div;
    logic [CNT_SIZE-1:0] r_cnt;
    logic                r_busy;

    logic [XLEN:0]       w_shift;
    logic [XLEN-1:0]     w_sub;
    logic                w_ge;

    // Partial remainder shifted left with the next dividend bit; the
    // subtract only needs XLEN bits because a taken subtract leaves < divisor.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[XLEN-1:0] - r_div;
    assign o_rem   = w_ge ? w_sub : w_shift[XLEN-1:0];
    assign o_quo   = {r_quo[XLEN-2:0], w_ge};
    assign o_last  = r_busy && (r_cnt == CNT_SIZE'(1));

    // Load operands on start, then shift one quotient bit in per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_kill) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            // Word dividends are pre-aligned so their MSB is shifted out first
            r_quo  <= i_word ? (i_dividend << HALF) : i_dividend;
            r_rem  <= '0;
            r_div  <= i_divisor;
            r_cnt  <= i_word ? CNT_SIZE'(HALF) : CNT_SIZE'(XLEN);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_quo <= o_quo;
            r_rem <= o_rem;
            r_cnt <= r_cnt - CNT_SIZE'(1);
            if (o_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: RV64M multiply/divide unit with valid/ready handshakes.
// Multiplies take one MUL cycle; divides iterate in div_iter; divide-by-zero
// and signed overflow resolve at accept.
// Optional: define MULDIV_DIV_EARLY_OUT_EN to also resolve, at accept, any
// divide whose dividend magnitude is below the divisor magnitude.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned SEL_SIZE = 4,
    parameter int unsigned CNT_SIZE = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_SIZE-1:0] sel,
    input  logic [XLEN-1:0]     data_in_a,
    input  logic [XLEN-1:0]     data_in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     data_out,
    output logic                busy
);

    localparam int unsigned HALF = XLEN / 2;
    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    state_e          r_state;
    state_e          w_state_nxt;

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    op_e             r_op;
    logic            r_known;
    logic            r_word;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_data_out;

    op_e             w_op;
    logic            w_known;
    logic            w_accept;
    logic            w_word;
    logic            w_signed;
    logic            w_is_div;
    logic            w_is_rem;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_a_sx;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic            w_early;
    logic [XLEN-1:0] w_spec_res;
    logic            w_div_start;

    logic            w_div_last;
    logic [XLEN-1:0] w_div_quo;
    logic [XLEN-1:0] w_div_rem;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_div_raw;
    logic [XLEN-1:0] w_div_res;

    logic              w_mul_sa;
    logic              w_mul_sb;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    // ---------------- request decode ----------------
    assign w_known  = (32'(sel) <= 32'(OP_REMUW));
    assign w_op     = op_e'(OP_SEL_W'(sel));
    assign w_is_div = w_known && is_div_op(w_op);
    assign w_is_rem = w_known && is_rem_op(w_op);
    assign w_word   = w_known && is_word_op(w_op);
    assign w_signed = w_is_div && is_signed_op(w_op);
    assign w_accept = in_valid && in_ready;

    assign w_a_ext = !w_word  ? data_in_a :
                     w_signed ? sext_half(data_in_a[HALF-1:0]) :
                                {{HALF{1'b0}}, data_in_a[HALF-1:0]};
    assign w_b_ext = !w_word  ? data_in_b :
                     w_signed ? sext_half(data_in_b[HALF-1:0]) :
                                {{HALF{1'b0}}, data_in_b[HALF-1:0]};
    assign w_a_neg = w_signed && w_a_ext[XLEN-1];
    assign w_b_neg = w_signed && w_b_ext[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_a_sx  = w_word ? sext_half(data_in_a[HALF-1:0]) : data_in_a;

    assign w_b_zero  = (w_b_ext == '0);
    assign w_ovf     = w_signed && (w_b_ext == '1) &&
                       (w_a_ext == (w_word ? MIN_WORD : MIN_FULL));
    assign w_special = w_is_div && (w_b_zero || w_ovf);

`ifdef MULDIV_DIV_EARLY_OUT_EN
    assign w_early = w_is_div && !w_special && (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    // Results known at accept: divide-by-zero, overflow and early-out
    assign w_spec_res = w_b_zero ? (w_is_rem ? w_a_sx : '1) :
                        w_ovf    ? (w_is_rem ? '0 : w_a_sx) :
                                   (w_is_rem ? w_a_sx : '0);

    assign w_div_start = w_accept && w_is_div && !w_special && !w_early;

    // ---------------- divider ----------------
    div_iter #(
        .XLEN     (XLEN),
        .CNT_SIZE (CNT_SIZE)
    ) u_div_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_kill     (flush),
        .i_start    (w_div_start),
        .i_word     (w_word),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_last     (w_div_last),
        .o_quo      (w_div_quo),
        .o_rem      (w_div_rem)
    );

    assign w_q_fix   = r_neg_q ? -w_div_quo : w_div_quo;
    assign w_r_fix   = r_neg_r ? -w_div_rem : w_div_rem;
    assign w_div_raw = r_is_rem ? w_r_fix : w_q_fix;
    assign w_div_res = r_word ? sext_half(w_div_raw[HALF-1:0]) : w_div_raw;

    // ---------------- multiplier ----------------
    // Operands are extended to 2*XLEN so one unsigned multiply covers every
    // signedness combination.
    assign w_mul_sa = r_known && is_signed_op(r_op);
    assign w_mul_sb = r_known && (r_op == OP_MULH);
    assign w_mul_a  = {{XLEN{w_mul_sa & r_a[XLEN-1]}}, r_a};
    assign w_mul_b  = {{XLEN{w_mul_sb & r_b[XLEN-1]}}, r_b};
    assign w_prod   = w_mul_a * w_mul_b;

    // Select product half per op; unlisted codes give zero
    always_comb begin
        w_mul_res = '0;
        if (r_known && is_mul_op(r_op)) begin
            case (r_op)
                OP_MUL:                       w_mul_res = w_prod[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: w_mul_res = w_prod[2*XLEN-1:XLEN];
                OP_MULW:                      w_mul_res = sext_half(w_prod[HALF-1:0]);
                default:                      w_mul_res = '0;
            endcase
        end
    end

    // ---------------- FSM ----------------
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_special || w_early) w_state_nxt = ST_DONE;
                    else if (w_is_div)        w_state_nxt = ST_DIV;
                    else                      w_state_nxt = ST_MUL;
                end
            end
            ST_MUL:  w_state_nxt = ST_DONE;
            ST_DIV:  if (w_div_last) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (r_state == ST_IDLE) && !flush;
        out_valid = (r_state == ST_DONE);
        busy      = (r_state != ST_IDLE);
    end

    // Operand capture at accept and result register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_MUL;
            r_known    <= 1'b0;
            r_word     <= 1'b0;
            r_is_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_data_out <= '0;
        end else if (w_accept) begin
            r_a      <= data_in_a;
            r_b      <= data_in_b;
            r_op     <= w_op;
            r_known  <= w_known;
            r_word   <= w_word;
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_special || w_early) begin
                r_data_out <= w_spec_res;
            end
        end else if (!flush) begin
            if (r_state == ST_MUL) begin
                r_data_out <= w_mul_res;
            end else if ((r_state == ST_DIV) && w_div_last) begin
                r_data_out <= w_div_res;
            end
        end
    end

    assign data_out = r_data_out;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table, multi-cycle corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [63:0] data_in_a;
    logic [63:0] data_in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULDIV_DIV_EARLY_OUT_EN
    localparam int SMALL_DIV_LAT = 1;
`else
    localparam int SMALL_DIV_LAT = 65;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    mul_div_unit #(
        .XLEN     (64),
        .SEL_SIZE (4),
        .CNT_SIZE (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .data_in_a (data_in_a),
        .data_in_b (data_in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference results straight from the RV64M arithmetic rules
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        longint            sa;
        longint            sb;
        int                sa32;
        int                sb32;
        logic [31:0]       ua32;
        logic [31:0]       ub32;
        logic signed [127:0] ps;
        logic [127:0]      pu;
        logic              ovf64;
        logic              ovf32;
        sa = a; sb = b;
        sa32 = a[31:0]; sb32 = b[31:0];
        ua32 = a[31:0]; ub32 = b[31:0];
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
        ovf32 = (ua32 == 32'h8000_0000) && (ub32 == '1);
        case (op)
            OP_MUL:    return a * b;
            OP_MULH:   begin ps = 128'(sa) * 128'(sb); return ps[127:64]; end
            OP_MULHSU: begin ps = 128'(sa) * $signed({64'd0, b}); return ps[127:64]; end
            OP_MULHU:  begin pu = {64'd0, a} * {64'd0, b}; return pu[127:64]; end
            OP_DIV:    return (b == 0) ? '1 : ovf64 ? a : 64'(sa / sb);
            OP_DIVU:   return (b == 0) ? '1 : a / b;
            OP_REM:    return (b == 0) ? a : ovf64 ? '0 : 64'(sa % sb);
            OP_REMU:   return (b == 0) ? a : a % b;
            OP_MULW:   return sx32(32'(sa32 * sb32));
            OP_DIVW:   return (ub32 == 0) ? '1 : ovf32 ? sx32(ua32) : sx32(32'(sa32 / sb32));
            OP_DIVUW:  return (ub32 == 0) ? '1 : sx32(ua32 / ub32);
            OP_REMW:   return (ub32 == 0) ? sx32(ua32) : ovf32 ? '0 : sx32(32'(sa32 % sb32));
            OP_REMUW:  return (ub32 == 0) ? sx32(ua32) : sx32(ua32 % ub32);
            default:   return '0;
        endcase
    endfunction

    // Expected cycles from accept edge to the edge that first samples out_valid
    function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        logic        word;
        logic        sgn;
        logic [63:0] ea;
        logic [63:0] eb;
        if (op > 4'd12 || op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW})
            return 2;
        word = op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        sgn  = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        ea = !word ? a : sgn ? sx32(a[31:0]) : {32'd0, a[31:0]};
        eb = !word ? b : sgn ? sx32(b[31:0]) : {32'd0, b[31:0]};
        if (eb == 0) return 1;
        if (sgn && eb == '1 && ea == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))
            return 1;
`ifdef MULDIV_DIV_EARLY_OUT_EN
        begin
            logic [63:0] ma;
            logic [63:0] mb;
            ma = (sgn && ea[63]) ? -ea : ea;
            mb = (sgn && eb[63]) ? -eb : eb;
            if (ma < mb) return 1;
        end
`endif
        return word ? 33 : 65;
    endfunction

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return {32'd0, $urandom};
            5:       return 64'hFFFF_FFFF_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
        int          got_lat;
        logic [63:0] got;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        sel = op; data_in_a = a; data_in_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        got_lat = 0;
        got     = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got_lat = k;
                got     = data_out;
                break;
            end
        end
        check({tag, "_latency"}, 64'(got_lat), 64'(lat));
        check({tag, "_data"}, got, exp);
        if (got_lat == 0) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end else begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            check({tag, "_idle_after"}, 64'(busy), 64'd0);
            check({tag, "_ovalid_after"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bit          seen;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; sel = '0;
        data_in_a = '0; data_in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // ---- directed vectors ----
        add_vec(OP_MUL,    64'd7, -64'd3, -64'd21, 2);
        add_vec(OP_MULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        add_vec(OP_MULH,   '1, '1, 64'd0, 2);
        add_vec(OP_MULHSU, '1, 64'd2, '1, 2);
        add_vec(OP_DIV,    -64'd20, 64'd3, -64'd6, 65);
        add_vec(OP_REM,    -64'd20, 64'd3, -64'd2, 65);
        add_vec(OP_DIVU,   64'd100, 64'd7, 64'd14, 65);
        add_vec(OP_DIV,    64'd5, 64'd0, '1, 1);
        add_vec(OP_REM,    64'h8000_0000_0000_0000, '1, 64'd0, 1);
        add_vec(OP_DIV,    64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        add_vec(OP_DIVW,   64'h1_0000_0010, 64'd4, 64'd4, 33);
        add_vec(OP_REMUW,  64'hFFFF_FFFF, 64'd2, 64'd1, 33);
        add_vec(OP_MULW,   64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        add_vec(OP_DIVU,   64'd3, 64'd9, 64'd0, SMALL_DIV_LAT);
        add_vec(OP_DIVW,   64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        add_vec(OP_REMW,   64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
        add_vec(OP_REMUW,  64'h1_8000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0005, 1);
        add_vec(4'd13,     64'd9, 64'd9, 64'd0, 2);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat);
        end

        // ---- backpressure: result held while out_ready is low ----
        @(negedge clk);
        sel = OP_MUL; data_in_a = 64'd3; data_in_b = 64'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        check("bp_result_seen", 64'(seen), 64'd1);
        sel = OP_DIVU; data_in_a = 64'd50; data_in_b = 64'd5; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_data_c%0d", k), data_out, 64'd12);
            check($sformatf("bp_in_ready_c%0d", k), 64'(in_ready), 64'd0);
            check($sformatf("bp_out_valid_c%0d", k), 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("bp_hs_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        check("bp_idle_busy", 64'(busy), 64'd0);
        check("bp_idle_out_valid", 64'(out_valid), 64'd0);
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);

        // ---- flush at iteration 10 of a DIV ----
        @(negedge clk);
        sel = OP_DIV; data_in_a = -64'd20; data_in_b = 64'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        sel = OP_MUL; data_in_a = 64'd1; data_in_b = 64'd1; in_valid = 1'b1;
        #1 check("fl_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_data_kept", data_out, 64'd12);
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check("fl_no_result", 64'(seen), 64'd0);

        // ---- reset asserted mid-DIV ----
        @(negedge clk);
        sel = OP_DIVU; data_in_a = 64'd1000; data_in_b = 64'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_data_out", data_out, 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check("mr_no_result", 64'(seen), 64'd0);

        // ---- randomized ops against the reference model ----
        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = rand_operand();
            b  = rand_operand();
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, model(op, a, b),
                   exp_lat(op, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
